score_board_mi: RTL and testbench
=================================

Name: score_board_mi

Overview:
- Parametrised, stateful register scoreboard for the out-of-decode issue stage.
- Tracks pending writes per architectural register file entry with saturating counters, so several writes to one register can be in flight.
- Checks up to ISSUE_WIDTH micro-ops per cycle, in order, against current state and against older slots in the same group.
- Retires up to WB_WIDTH writebacks per cycle.
- Replaces the single-op, single-bit combinational check in the issue logic.

Parameters:
- NUM_REGS, 16, register file entries tracked (matches REG_FILE_SIZE).
- IDX_W, $clog2(NUM_REGS), register index width.
- ISSUE_WIDTH, 2, micro-op slots checked per cycle.
- WB_WIDTH, 2, writeback ports per cycle.
- CNT_W, 2, pending-write counter width; max outstanding writes per reg = 2^CNT_W-1.
- WAW_STALL, 1, 1 = dst must have zero pending writes (legacy rule); 0 = dst only needs counter headroom.

Ports:
- clk in 1 clock
- reset in 1 synchronous, active-high reset
- flush in 1 pipeline flush; clears all pending state
- iss_valid in ISSUE_WIDTH per-slot micro-op present
- iss_src0_en in ISSUE_WIDTH src0 is a register file entry
- iss_src0 in ISSUE_WIDTH*IDX_W src0 index
- iss_src1_en in ISSUE_WIDTH src1 is a register file entry
- iss_src1 in ISSUE_WIDTH*IDX_W src1 index
- iss_dst_en in ISSUE_WIDTH dst is a register file entry
- iss_dst in ISSUE_WIDTH*IDX_W dst index
- iss_ready out ISSUE_WIDTH slot may issue this cycle; issue = valid & ready
- wb_valid in WB_WIDTH writeback completes
- wb_reg in WB_WIDTH*IDX_W writeback register index
- busy_mask out NUM_REGS bit r = pending count of r nonzero
- idle out 1 all counters zero
- err_underflow out 1 sticky; writeback arrived for a register with no pending write

Behaviour:
- State: cnt[r], CNT_W bits, r in 0..NUM_REGS-1; err flag.
- Reset: all counters 0, err_underflow=0, busy_mask=0, idle=1. iss_ready is combinational and therefore all-ones when state is clear and flush=0.
- Register fields with *_en=0 (rip, rimm, constants, nil) never stall and never update state.
- iss_ready[i] is combinational from the registered counters plus same-cycle slots j<i. All of the following must hold:
  - i==0, or iss_ready[i-1] is 1. Issue is strictly in order, so once a slot stalls, all younger slots stall.
  - Each enabled src: cnt==0, and no valid older slot j<i has dst_en with the same index (intra-group RAW).
  - Enabled dst, WAW_STALL=1: cnt==0 and no valid older slot targets the same dst.
  - Enabled dst, WAW_STALL=0: cnt plus the number of valid older slots targeting the same dst is less than 2^CNT_W-1.
  - flush==0.
- iss_ready does not depend on iss_valid[i] itself, so a slot with valid=0 still passes readiness through to younger slots.
- Same-cycle writeback is not forwarded: an issue check sees the pre-edge counter, so a register written back this cycle is still busy for issue this cycle.
- Next state per register r: cnt' = cnt + inc - dec.
  - inc = number of issued slots (valid & ready) with dst_en and dst==r.
  - dec = number of wb ports with wb_valid and wb_reg==r.
  - Simultaneous inc and dec on the same r net out.
- Underflow: if dec > cnt + inc, the counter clamps to 0 and err_underflow sets on the next edge. It stays set until reset.
- Overflow cannot occur, because the headroom check guarantees cnt' <= 2^CNT_W-1. A bench assertion checks this.
- flush=1: all iss_ready=0. On the next edge every counter clears to 0 and the same-cycle wb/issue updates are discarded. err_underflow is unaffected.
- reset has priority over flush.
- busy_mask and idle are decoded from the registered counters, with no added latency.
- Latency: an issue is visible in busy_mask one cycle after the issue edge. A writeback that zeros a counter makes the register issuable in the following cycle.

Decomposition:
- Shared package (RegMap / new ScoreboardTypes): sb_cnt_t, sb_idx_t, and a function mapping reg_id_t to {en, idx} via reg_in_file/reg_num. The decode-to-port mapping lives in the caller, not this module.
- One sub-module, score_board_hazard: the per-slot combinational readiness chain (ISSUE_WIDTH slots, intra-group compare). Counter update and writeback decrement stay in the top module.

Test Plan:
- After reset, slot0 dst=3, slot1 src0=3, both valid -> iss_ready=2'b01. Next cycle busy_mask[3]=1, cnt[3]=1.
- cnt[5]=1, wb_valid[0]=1 wb_reg=5 in the same cycle as slot0 src0=5 -> ready[0]=0 this cycle, =1 the next cycle, busy_mask[5]=0.
- WAW_STALL=0, CNT_W=2: issue dst=7 on three successive cycles -> all issue, cnt[7]=3. A fourth dst=7 gives ready=0 until one wb_reg=7.
- Slot0 stalls on a busy src while slot1 is independent -> iss_ready=2'b00, confirming in-order issue.
- wb_reg=9 with cnt[9]=0 -> cnt stays 0, err_underflow=1 from the next cycle and stays set until reset.
- Multiple regs pending, flush=1 for one cycle with a simultaneous issue -> iss_ready=0 during flush, then busy_mask=0 and idle=1. Reset mid-traffic clears all counters and err_underflow.

Source files
------------

// File: rtl/score_board_mi_pkg.sv
// Shared scoreboard types and the architectural-register to file-entry mapping.
// Callers use sb_map_reg to turn a decoded register id into the {en, idx} pair the ports take.
package score_board_mi_pkg;

    localparam int SB_NUM_REGS = 16;
    localparam int SB_CNT_W    = 2;
    localparam int SB_IDX_W    = $clog2(SB_NUM_REGS);

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;
    typedef logic [SB_IDX_W-1:0] sb_idx_t;

    // Ids below SB_NUM_REGS are file entries; the rest never touch the scoreboard.
    typedef logic [4:0] reg_id_t;
    typedef enum reg_id_t {
        REG_RIP   = 5'd16,
        REG_RIMM  = 5'd17,
        REG_CONST = 5'd18,
        REG_NIL   = 5'd31
    } reg_special_e;

    typedef struct packed {
        logic    en;
        sb_idx_t idx;
    } sb_field_t;

    function automatic logic reg_in_file(reg_id_t id);
        return id < 5'(SB_NUM_REGS);
    endfunction

    function automatic sb_idx_t reg_num(reg_id_t id);
        return id[SB_IDX_W-1:0];
    endfunction

    function automatic sb_field_t sb_map_reg(reg_id_t id);
        sb_field_t f;
        f.en  = reg_in_file(id);
        f.idx = f.en ? reg_num(id) : '0;
        return f;
    endfunction

endpackage

// File: rtl/score_board_mi_if.sv
// Issue-slot and writeback bundle between the issue stage (master) and the scoreboard (slave).
interface score_board_mi_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_WIDTH    = 2,
    parameter int IDX_W       = 4
);
    logic [ISSUE_WIDTH-1:0]       iss_valid;
    logic [ISSUE_WIDTH-1:0]       iss_src0_en;
    logic [ISSUE_WIDTH*IDX_W-1:0] iss_src0;
    logic [ISSUE_WIDTH-1:0]       iss_src1_en;
    logic [ISSUE_WIDTH*IDX_W-1:0] iss_src1;
    logic [ISSUE_WIDTH-1:0]       iss_dst_en;
    logic [ISSUE_WIDTH*IDX_W-1:0] iss_dst;
    logic [ISSUE_WIDTH-1:0]       iss_ready;
    logic [WB_WIDTH-1:0]          wb_valid;
    logic [WB_WIDTH*IDX_W-1:0]    wb_reg;

    modport master (
        output iss_valid, iss_src0_en, iss_src0, iss_src1_en, iss_src1,
               iss_dst_en, iss_dst, wb_valid, wb_reg,
        input  iss_ready
    );

    modport slave (
        input  iss_valid, iss_src0_en, iss_src0, iss_src1_en, iss_src1,
               iss_dst_en, iss_dst, wb_valid, wb_reg,
        output iss_ready
    );
endinterface

// File: rtl/score_board_mi_hazard.sv
// In-order readiness chain for one issue group: RAW/WAW against the registered
// counters and against older slots of the same group.
module score_board_hazard
    import score_board_mi_pkg::*;
#(
    parameter int NUM_REGS    = SB_NUM_REGS,
    parameter int IDX_W       = $clog2(NUM_REGS),
    parameter int ISSUE_WIDTH = 2,
    parameter int CNT_W       = SB_CNT_W,
    parameter bit WAW_STALL   = 1'b1
) (
    input  logic [CNT_W-1:0]             cnt [NUM_REGS],
    input  logic                         flush,
    input  logic [ISSUE_WIDTH-1:0]       valid,
    input  logic [ISSUE_WIDTH-1:0]       src0_en,
    input  logic [ISSUE_WIDTH*IDX_W-1:0] src0,
    input  logic [ISSUE_WIDTH-1:0]       src1_en,
    input  logic [ISSUE_WIDTH*IDX_W-1:0] src1,
    input  logic [ISSUE_WIDTH-1:0]       dst_en,
    input  logic [ISSUE_WIDTH*IDX_W-1:0] dst,
    output logic [ISSUE_WIDTH-1:0]       ready
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             prev;
    logic             ok;
    int               older;
    logic [IDX_W-1:0] s0, s1, d;

    // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        ready = '0;
        prev  = !flush;
        ok    = 1'b0;
        older = 0;
        s0    = '0;
        s1    = '0;
        d     = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            s0    = src0[i*IDX_W +: IDX_W];
            s1    = src1[i*IDX_W +: IDX_W];
            d     = dst[i*IDX_W +: IDX_W];
            ok    = prev;
            older = 0;
            if (src0_en[i] && cnt[s0] != '0) ok = 1'b0;
            if (src1_en[i] && cnt[s1] != '0) ok = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (valid[j] && dst_en[j]) begin
                    if (src0_en[i] && dst[j*IDX_W +: IDX_W] == s0) ok = 1'b0;
                    if (src1_en[i] && dst[j*IDX_W +: IDX_W] == s1) ok = 1'b0;
                    if (dst_en[i] && dst[j*IDX_W +: IDX_W] == d) older = older + 1;
                end
            end
            if (dst_en[i]) begin
                if (WAW_STALL) begin
                    if (cnt[d] != '0 || older != 0) ok = 1'b0;
                end else if (int'(cnt[d]) + older >= CNT_MAX) begin
                    ok = 1'b0;
                end
            end
            // A non-valid slot still forwards its readiness to younger slots.
            ready[i] = ok;
            prev     = ok;
        end
    end

endmodule

// File: rtl/score_board_mi.sv
// Multi-issue register scoreboard: saturating pending-write counters per register,
// up to ISSUE_WIDTH issues and WB_WIDTH writebacks per cycle, sticky underflow flag.
module score_board_mi
    import score_board_mi_pkg::*;
#(
    parameter int NUM_REGS    = SB_NUM_REGS,
    parameter int IDX_W       = $clog2(NUM_REGS),
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_WIDTH    = 2,
    parameter int CNT_W       = SB_CNT_W,
    parameter bit WAW_STALL   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    score_board_mi_if.slave     sb,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                idle,
    output logic                err_underflow
);

    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
    logic             underflow;
    int               sum;

    score_board_hazard #(
        .NUM_REGS    (NUM_REGS),
        .IDX_W       (IDX_W),
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .CNT_W       (CNT_W),
        .WAW_STALL   (WAW_STALL)
    ) u_hazard (
        .cnt     (cnt),
        .flush   (flush),
        .valid   (sb.iss_valid),
        .src0_en (sb.iss_src0_en),
        .src0    (sb.iss_src0),
        .src1_en (sb.iss_src1_en),
        .src1    (sb.iss_src1),
        .dst_en  (sb.iss_dst_en),
        .dst     (sb.iss_dst),
        .ready   (sb.iss_ready)
    );

    always_comb begin
        underflow = 1'b0;
        sum       = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sum = int'(cnt[r]);
            for (int i = 0; i < ISSUE_WIDTH; i++)
                if (sb.iss_valid[i] && sb.iss_ready[i] && sb.iss_dst_en[i] &&
                    sb.iss_dst[i*IDX_W +: IDX_W] == IDX_W'(r))
                    sum = sum + 1;
            for (int p = 0; p < WB_WIDTH; p++)
                if (sb.wb_valid[p] && sb.wb_reg[p*IDX_W +: IDX_W] == IDX_W'(r))
                    sum = sum - 1;
            // Readiness guarantees sum never exceeds CNT_MAX; only the low side needs clamping.
            if (sum < 0) begin
                underflow  = 1'b1;
                cnt_nxt[r] = '0;
            end else begin
                cnt_nxt[r] = CNT_W'(sum);
            end
        end
    end

    // NOTE: the counter array is plain flops, not RAM, so it is reset explicitly along with the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
            err_underflow <= err_underflow | underflow;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) busy_mask[r] = |cnt[r];
    end

    assign idle = ~|busy_mask;

endmodule

// File: tb/tb_score_board_mi.sv
// Directed bench: one scoreboard with the legacy WAW rule and one with counter headroom,
// both fed identical stimulus.
module tb_score_board_mi;
    import score_board_mi_pkg::*;

    localparam int NR = 16;
    localparam int IW = 2;
    localparam int WW = 2;
    localparam int XW = 4;

    logic clk;
    logic reset;
    logic flush;

    logic [IW-1:0]    iss_valid, iss_src0_en, iss_src1_en, iss_dst_en;
    logic [IW*XW-1:0] iss_src0, iss_src1, iss_dst;
    logic [WW-1:0]    wb_valid;
    logic [WW*XW-1:0] wb_reg;

    logic [NR-1:0] busy_a, busy_b;
    logic          idle_a, idle_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    score_board_mi_if #(.ISSUE_WIDTH(IW), .WB_WIDTH(WW), .IDX_W(XW)) sb_a ();
    score_board_mi_if #(.ISSUE_WIDTH(IW), .WB_WIDTH(WW), .IDX_W(XW)) sb_b ();

    assign sb_a.iss_valid = iss_valid;   assign sb_b.iss_valid = iss_valid;
    assign sb_a.iss_src0_en = iss_src0_en; assign sb_b.iss_src0_en = iss_src0_en;
    assign sb_a.iss_src0 = iss_src0;     assign sb_b.iss_src0 = iss_src0;
    assign sb_a.iss_src1_en = iss_src1_en; assign sb_b.iss_src1_en = iss_src1_en;
    assign sb_a.iss_src1 = iss_src1;     assign sb_b.iss_src1 = iss_src1;
    assign sb_a.iss_dst_en = iss_dst_en; assign sb_b.iss_dst_en = iss_dst_en;
    assign sb_a.iss_dst = iss_dst;       assign sb_b.iss_dst = iss_dst;
    assign sb_a.wb_valid = wb_valid;     assign sb_b.wb_valid = wb_valid;
    assign sb_a.wb_reg = wb_reg;         assign sb_b.wb_reg = wb_reg;

    score_board_mi #(.NUM_REGS(NR), .ISSUE_WIDTH(IW), .WB_WIDTH(WW), .CNT_W(2), .WAW_STALL(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .sb(sb_a.slave),
        .busy_mask(busy_a), .idle(idle_a), .err_underflow(err_a)
    );

    score_board_mi #(.NUM_REGS(NR), .ISSUE_WIDTH(IW), .WB_WIDTH(WW), .CNT_W(2), .WAW_STALL(1'b0)) dut_w0 (
        .clk(clk), .reset(reset), .flush(flush), .sb(sb_b.slave),
        .busy_mask(busy_b), .idle(idle_b), .err_underflow(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        iss_valid = '0; iss_src0_en = '0; iss_src1_en = '0; iss_dst_en = '0;
        iss_src0 = '0; iss_src1 = '0; iss_dst = '0;
        wb_valid = '0; wb_reg = '0;
    endtask

    task automatic slot(input int i, input reg_id_t s0, input reg_id_t s1, input reg_id_t d);
        sb_field_t f0, f1, fd;
        f0 = sb_map_reg(s0);
        f1 = sb_map_reg(s1);
        fd = sb_map_reg(d);
        iss_valid[i] = 1'b1;
        iss_src0_en[i] = f0.en; iss_src0[i*XW +: XW] = f0.idx;
        iss_src1_en[i] = f1.en; iss_src1[i*XW +: XW] = f1.idx;
        iss_dst_en[i]  = fd.en; iss_dst[i*XW +: XW]  = fd.idx;
    endtask

    task automatic wb(input int p, input int r);
        wb_valid[p] = 1'b1;
        wb_reg[p*XW +: XW] = XW'(r);
    endtask

    // Issued-this-cycle count into register r of the headroom instance.
    function automatic int issued_b(input int r);
        int n = 0;
        for (int i = 0; i < IW; i++)
            if (iss_valid[i] && sb_b.iss_ready[i] && iss_dst_en[i] && iss_dst[i*XW +: XW] == XW'(r))
                n++;
        return n;
    endfunction

    always @(negedge clk) begin
        if (!reset)
            for (int r = 0; r < NR; r++)
                assert (int'(dut_w0.cnt[r]) + issued_b(r) <= 3)
                    else $error("counter overflow on reg %0d", r);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        clr();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_idle", idle_a, 1);
        check("rst_err", err_a, 0);
        check("rst_ready", sb_a.iss_ready, 2'b11);
        check("rst_ready_b", sb_b.iss_ready, 2'b11);

        // Intra-group RAW: slot1 reads what slot0 writes.
        slot(0, REG_NIL, REG_NIL, 5'd3);
        slot(1, 5'd3, REG_NIL, REG_NIL);
        #1 check("raw_group_ready", sb_a.iss_ready, 2'b01);
        tick(); clr(); #1;
        check("raw_busy3", busy_a, 16'h0008);
        check("raw_cnt3", dut.cnt[3], 1);

        // No writeback forwarding.
        slot(0, REG_NIL, REG_NIL, 5'd5);
        tick(); clr();
        slot(0, 5'd5, REG_NIL, REG_NIL);
        wb(0, 5);
        #1 check("wb_nofwd_ready", sb_a.iss_ready, 2'b00);
        tick(); wb_valid = '0;
        #1 check("wb_next_ready", sb_a.iss_ready, 2'b11);
        check("wb_busy", busy_a, 16'h0008);
        tick(); clr();
        wb(0, 3);
        tick(); clr(); #1;
        check("wb_idle", idle_a, 1);

        // In-order: slot0 stalls on src1, independent slot1 stalls too.
        slot(0, REG_NIL, REG_NIL, 5'd4);
        tick(); clr();
        slot(0, REG_NIL, 5'd4, REG_NIL);
        slot(1, 5'd1, REG_NIL, 5'd6);
        #1 check("inorder_ready", sb_a.iss_ready, 2'b00);
        clr();
        wb(0, 4);
        tick(); clr(); #1;
        check("inorder_idle", idle_a, 1);

        // WAW: legacy rule blocks the second write, headroom allows three.
        slot(0, REG_NIL, REG_NIL, 5'd7);
        #1 check("waw1_a", sb_a.iss_ready, 2'b11);
        tick();
        #1 check("waw2_a", sb_a.iss_ready, 2'b00);
        check("waw2_b", sb_b.iss_ready, 2'b11);
        tick();
        #1 check("waw3_b", sb_b.iss_ready, 2'b11);
        tick();
        #1 check("waw4_b", sb_b.iss_ready, 2'b00);
        check("waw_cnt7_b", dut_w0.cnt[7], 3);
        wb(0, 7);
        #1 check("waw_wb_same_b", sb_b.iss_ready, 2'b00);
        tick(); wb_valid = '0;
        #1 check("waw_after_wb_b", sb_b.iss_ready, 2'b11);
        check("waw_cnt7_b2", dut_w0.cnt[7], 2);
        tick(); clr(); #1;
        check("waw_cnt7_b3", dut_w0.cnt[7], 3);
        check("waw_cnt7_a", dut.cnt[7], 1);

        // Intra-group WAW.
        slot(0, REG_NIL, REG_NIL, 5'd8);
        slot(1, REG_NIL, REG_NIL, 5'd8);
        #1 check("waw_group_a", sb_a.iss_ready, 2'b01);
        check("waw_group_b", sb_b.iss_ready, 2'b11);
        clr();

        // Flush with a simultaneous issue.
        slot(0, REG_NIL, REG_NIL, 5'd10);
        flush = 1'b1;
        #1 check("flush_ready_a", sb_a.iss_ready, 2'b00);
        check("flush_ready_b", sb_b.iss_ready, 2'b00);
        tick(); flush = 1'b0; clr(); #1;
        check("flush_busy_a", busy_a, 0);
        check("flush_idle_a", idle_a, 1);
        check("flush_idle_b", idle_b, 1);

        // Underflow is sticky, survives flush.
        check("uf_before", err_a, 0);
        wb(0, 9);
        tick(); clr(); #1;
        check("uf_err_a", err_a, 1);
        check("uf_err_b", err_b, 1);
        check("uf_cnt9", dut.cnt[9], 0);
        tick();
        check("uf_sticky", err_a, 1);
        flush = 1'b1;
        tick(); flush = 1'b0; #1;
        check("uf_flush", err_a, 1);

        // Simultaneous inc and dec on one register net out.
        slot(0, REG_NIL, REG_NIL, 5'd2);
        tick();
        wb(0, 2);
        #1 check("net_ready_a", sb_a.iss_ready, 2'b00);
        check("net_ready_b", sb_b.iss_ready, 2'b11);
        tick(); clr(); #1;
        check("net_cnt2_b", dut_w0.cnt[2], 1);
        check("net_busy_a", busy_a, 0);

        // Reset mid-traffic.
        slot(0, REG_NIL, REG_NIL, 5'd11);
        tick();
        clr();
        slot(0, REG_NIL, REG_NIL, 5'd12);
        reset = 1'b1;
        tick(); reset = 1'b0; clr(); #1;
        check("rst2_busy_a", busy_a, 0);
        check("rst2_idle_b", idle_b, 1);
        check("rst2_err_a", err_a, 0);
        check("rst2_err_b", err_b, 0);
        check("rst2_ready", sb_a.iss_ready, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
